// File: rtl/frq_div.sv
// Integer clock divider: derives a registered, near-50% duty square wave clk
// from mclk, with period DIV mclk cycles and phase fixed to the reset release.
module frq_div #(
    parameter int DIV = 10
) (
    input  logic mclk,
    input  logic rst,
    output logic clk
);

    localparam int CNT_W   = $clog2(DIV);
    localparam int LOW_CYC = DIV - DIV / 2;

    if (DIV < 2) begin : g_div_chk
        $fatal(1, "frq_div: DIV must be >= 2");
    end

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             clk_q;
    logic             clk_d;

    // The output level is decoded from the next count, so clk_q lands in the
    // same edge as the count it belongs to and no decode sits on the pin.
    always_comb begin
        cnt_d = (cnt_q == CNT_W'(DIV - 1)) ? '0 : cnt_q + 1'b1;
        clk_d = (cnt_d >= CNT_W'(LOW_CYC));
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            clk_q <= 1'b0;
        end else begin
            clk_q <= clk_d;
        end
    end

    assign clk = clk_q;

endmodule

// File: tb/tb_frq_div.sv
// Bench for frq_div: three instances (DIV=10, 2, 5) checked every cycle against
// an edge-count model, plus literal timing pins and random mid-run resets.
module tb_frq_div;

    logic mclk;
    logic rst10, rst2, rst5;
    logic clk10, clk2, clk5;

    int checks   = 0;
    int failures = 0;

    frq_div #(.DIV(10)) u10 (.mclk(mclk), .rst(rst10), .clk(clk10));
    frq_div #(.DIV(2))  u2  (.mclk(mclk), .rst(rst2),  .clk(clk2));
    frq_div #(.DIV(5))  u5  (.mclk(mclk), .rst(rst5),  .clk(clk5));

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Model: k = rising edges since the last edge that sampled reset high.
    // Expected: cnt = k mod DIV, clk = 1 when (k mod DIV) >= DIV - floor(DIV/2).
    int k10 = 0, k2 = 0, k5 = 0;
    bit v10 = 0, v2 = 0, v5 = 0;

    always @(posedge mclk) begin
        if (rst10) begin k10 <= 0; v10 <= 1'b1; end else k10 <= k10 + 1;
        if (rst2)  begin k2  <= 0; v2  <= 1'b1; end else k2  <= k2 + 1;
        if (rst5)  begin k5  <= 0; v5  <= 1'b1; end else k5  <= k5 + 1;
    end

    function automatic logic exp_clk(input int k, input int div);
        return ((k % div) >= (div - div / 2));
    endfunction

    always @(negedge mclk) begin
        if (v10) begin
            cmp("clk10_model", 32'(clk10), 32'(exp_clk(k10, 10)));
            cmp("cnt10_model", 32'(u10.cnt_q), 32'(k10 % 10));
        end
        if (v2) begin
            cmp("clk2_model", 32'(clk2), 32'(exp_clk(k2, 2)));
            cmp("cnt2_model", 32'(u2.cnt_q), 32'(k2 % 2));
        end
        if (v5) begin
            cmp("clk5_model", 32'(clk5), 32'(exp_clk(k5, 5)));
            cmp("cnt5_model", 32'(u5.cnt_q), 32'(k5 % 5));
        end
    end

    // Output transitions may only occur in the time step of a mclk rising edge.
    time last_pos = 0;
    always @(posedge mclk) last_pos = $time;
    always @(clk10 or clk2 or clk5) begin
        if ($time > 0) cmp("glitch_free", 32'($time), 32'(last_pos));
    end

    int  rises10   = 0;
    bit  count_en  = 0;
    always @(posedge clk10) if (count_en) rises10++;

    task automatic tick(input int n);
        repeat (n) @(posedge mclk);
        #2;
    endtask

    // Literal pins from the timing diagram: reset sampled at the 15 ns edge.
    initial begin
        #20;  cmp("lit10_t20",  32'(clk10), 32'd0);
              cmp("lit2_t20",   32'(clk2),  32'd0);
              cmp("lit5_t20",   32'(clk5),  32'd0);
        #10;  cmp("lit2_t30",   32'(clk2),  32'd1);
        #10;  cmp("lit2_t40",   32'(clk2),  32'd0);
              cmp("lit5_t40",   32'(clk5),  32'd0);
        #10;  cmp("lit2_t50",   32'(clk2),  32'd1);
              cmp("lit5_t50",   32'(clk5),  32'd1);
        #10;  cmp("lit10_t60",  32'(clk10), 32'd0);
              cmp("lit5_t60",   32'(clk5),  32'd1);
        #10;  cmp("lit10_t70",  32'(clk10), 32'd1);
              cmp("lit5_t70",   32'(clk5),  32'd0);
        #20;  cmp("lit5_t90",   32'(clk5),  32'd0);
        #10;  cmp("lit5_t100",  32'(clk5),  32'd1);
        #10;  cmp("lit10_t110", 32'(clk10), 32'd1);
        #10;  cmp("lit10_t120", 32'(clk10), 32'd0);
        #40;  cmp("lit10_t160", 32'(clk10), 32'd0);
        #10;  cmp("lit10_t170", 32'(clk10), 32'd1);
    end

    initial begin
        rst10 = 1'b0; rst2 = 1'b0; rst5 = 1'b0;
        #12;
        rst10 = 1'b1; rst2 = 1'b1; rst5 = 1'b1;
        #5;
        rst10 = 1'b0; rst2 = 1'b0; rst5 = 1'b0;
        count_en = 1'b1;

        // Long run: edges 1..1000 after release hold exactly 100 rising edges.
        tick(1000);
        count_en = 1'b0;
        cmp("rises_1000", 32'(rises10), 32'd100);

        // Reset in the high phase: sampled on edge 1007 (clk10 high there).
        tick(6);
        cmp("pre_midrst_high", 32'(clk10), 32'd1);
        rst10 = 1'b1;
        tick(1);
        cmp("midrst_clk", 32'(clk10), 32'd0);
        cmp("midrst_cnt", 32'(u10.cnt_q), 32'd0);
        rst10 = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            cmp("midrst_low", 32'(clk10), 32'd0);
        end
        tick(1);
        cmp("midrst_rise", 32'(clk10), 32'd1);

        // Reset held for 20 edges: everything stays low.
        rst10 = 1'b1; rst2 = 1'b1; rst5 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            cmp("hold_clk10", 32'(clk10), 32'd0);
            cmp("hold_clk2",  32'(clk2),  32'd0);
            cmp("hold_clk5",  32'(clk5),  32'd0);
        end
        rst10 = 1'b0; rst2 = 1'b0; rst5 = 1'b0;
        tick(1);
        cmp("hold_rel_clk2", 32'(clk2), 32'd1);
        tick(1);
        cmp("hold_rel_clk5_e2", 32'(clk5), 32'd0);
        tick(1);
        cmp("hold_rel_clk5_e3", 32'(clk5), 32'd1);
        tick(1);
        cmp("hold_rel_clk10_e4", 32'(clk10), 32'd0);
        tick(1);
        cmp("hold_rel_clk10_e5", 32'(clk10), 32'd1);

        // Random resets of random length at random phases.
        for (int c = 0; c < 2000; c++) begin
            rst10 = ($urandom_range(0, 40) == 0);
            rst2  = ($urandom_range(0, 40) == 0);
            rst5  = ($urandom_range(0, 40) == 0);
            tick(1);
            if ($urandom_range(0, 3) == 0) tick($urandom_range(0, 3));
        end
        rst10 = 1'b0; rst2 = 1'b0; rst5 = 1'b0;
        tick(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
